// File: rtl/mem_bist.sv
// Fill-and-check memory BIST: writes an incrementing pattern over a window of
// addresses, reads it back with a two-cycle beat, and reports mismatches.
module mem_bist #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [ADDR_BITS:0]    count,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_BITS:0]    err_count,
  output logic [ADDR_BITS-1:0]  first_err_addr
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD_ADDR, S_RD_CMP, S_DONE} state_t;

  localparam logic [ADDR_BITS:0] MAX_N = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] ONE   = (ADDR_BITS+1)'(1);

  state_t                r_state,    w_state;
  logic [ADDR_BITS-1:0]  r_base,     w_base;
  logic [DATA_WIDTH-1:0] r_seed,     w_seed;
  logic [ADDR_BITS:0]    r_n,        w_n;
  logic [ADDR_BITS:0]    r_idx,      w_idx;
  logic [ADDR_BITS-1:0]  r_mem_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_din,  w_mem_din;
  logic                  r_mem_wen,  w_mem_wen;
  logic                  r_busy,     w_busy;
  logic                  r_done,     w_done;
  logic                  r_pass,     w_pass;
  logic [ADDR_BITS:0]    r_err,      w_err;
  logic [ADDR_BITS-1:0]  r_ferr,     w_ferr;

  logic [ADDR_BITS:0]    w_idx_inc;
  logic                  w_last;
  logic [ADDR_BITS-1:0]  w_addr_next;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic [DATA_WIDTH-1:0] w_exp_data;
  logic [ADDR_BITS:0]    w_cnt_sat;
  logic                  w_active;

  assign w_idx_inc   = r_idx + ONE;
  assign w_last      = (w_idx_inc == r_n);
  assign w_addr_next = r_base + w_idx_inc[ADDR_BITS-1:0];
  assign w_data_next = r_seed + DATA_WIDTH'(w_idx_inc);
  assign w_exp_data  = r_seed + DATA_WIDTH'(r_idx);
  assign w_cnt_sat   = (count > MAX_N) ? MAX_N : count;
  assign w_active    = (r_state == S_WRITE) || (r_state == S_RD_ADDR) || (r_state == S_RD_CMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_seed     <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_wen  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_ferr     <= '0;
    end else begin
      r_state    <= w_state;
      r_base     <= w_base;
      r_seed     <= w_seed;
      r_n        <= w_n;
      r_idx      <= w_idx;
      r_mem_addr <= w_mem_addr;
      r_mem_din  <= w_mem_din;
      r_mem_wen  <= w_mem_wen;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_pass     <= w_pass;
      r_err      <= w_err;
      r_ferr     <= w_ferr;
    end
  end

  // Outputs are computed here for the next state so every port comes from a flop.
  always_comb begin
    w_state    = r_state;
    w_base     = r_base;
    w_seed     = r_seed;
    w_n        = r_n;
    w_idx      = r_idx;
    w_mem_addr = r_mem_addr;
    w_mem_din  = r_mem_din;
    w_mem_wen  = r_mem_wen;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_pass     = r_pass;
    w_err      = r_err;
    w_ferr     = r_ferr;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_base = base_addr;
          w_seed = seed;
          w_n    = w_cnt_sat;
          w_idx  = '0;
          w_err  = '0;
          w_ferr = '0;
          w_pass = 1'b0;
          if (w_cnt_sat != '0) begin
            w_state    = S_WRITE;
            w_busy     = 1'b1;
            w_mem_wen  = 1'b1;
            w_mem_addr = base_addr;
            w_mem_din  = seed;
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_pass  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_state    = S_RD_ADDR;
          w_idx      = '0;
          w_mem_wen  = 1'b0;
          w_mem_addr = r_base;
          w_mem_din  = '0;
        end else begin
          w_idx      = w_idx_inc;
          w_mem_addr = w_addr_next;
          w_mem_din  = w_data_next;
        end
      end
      S_RD_ADDR: w_state = S_RD_CMP;
      S_RD_CMP: begin
        if (mem_dout != w_exp_data) begin
          w_err = r_err + ONE;
          if (r_err == '0) w_ferr = r_mem_addr;
        end
        if (w_last) begin
          w_state    = S_DONE;
          w_done     = 1'b1;
          w_busy     = 1'b0;
          w_mem_addr = '0;
          w_pass     = (w_err == '0);
        end else begin
          w_state    = S_RD_ADDR;
          w_idx      = w_idx_inc;
          w_mem_addr = w_addr_next;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Abort overrides whatever the active state decided, freezing the results.
    if (abort && w_active) begin
      w_state    = S_IDLE;
      w_mem_wen  = 1'b0;
      w_mem_addr = '0;
      w_mem_din  = '0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      w_pass     = 1'b0;
      w_err      = r_err;
      w_ferr     = r_ferr;
    end
  end

  assign mem_addr       = r_mem_addr;
  assign mem_din        = r_mem_din;
  assign mem_wen        = r_mem_wen;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_ferr;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: memory model with stuck-value faults, cycle-indexed
// behavioural model of each run, directed scenarios plus randomized runs.
module tb_mem_bist;
  localparam int DW = 8;
  localparam int AB = 5;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AB-1:0] base_addr = '0;
  logic [AB:0]   count = '0;
  logic [DW-1:0] seed = '0;
  logic [AB-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_wen;
  logic [DW-1:0] mem_dout;
  logic          busy, done, pass;
  logic [AB:0]   err_count;
  logic [AB-1:0] first_err_addr;

  always #5 clk = ~clk;

  mem_bist #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .seed(seed),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  // Memory: faulty addresses always return their stuck value; optional read register.
  logic [DW-1:0] tb_mem [NW];
  bit            f_en   [NW];
  logic [DW-1:0] f_val  [NW];
  logic [DW-1:0] rd_q = '0;
  bit            mem_reg = 1'b0;

  always @(posedge clk) begin
    if (mem_wen) tb_mem[mem_addr] <= mem_din;
    rd_q <= f_en[mem_addr] ? f_val[mem_addr] : tb_mem[mem_addr];
  end
  assign mem_dout = mem_reg ? rd_q : (f_en[mem_addr] ? f_val[mem_addr] : tb_mem[mem_addr]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the current run; cycle c is the c-th clock period after the start edge.
  int kind = 0;
  int t_start = 0;
  int m_n = 0, m_base = 0, m_seed = 0, m_ab = 0;
  bit mm [NW];
  int total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int errs_at(input int c);
    int n = 0;
    for (int j = 0; j < m_n; j++)
      if (mm[j] && (m_n + 2*j + 3 <= c)) n++;
    return n;
  endfunction

  function automatic int ferr_at(input int c);
    for (int j = 0; j < m_n; j++)
      if (mm[j] && (m_n + 2*j + 3 <= c)) return (m_base + j) % NW;
    return 0;
  endfunction

  always @(negedge clk) begin : compare
    int c, lim, e_wen, e_addr, e_din, e_busy, e_done, e_pass, e_err, e_ferr;
    bit aborted, ck_din;
    c = cyc - t_start;
    e_wen = 0; e_addr = 0; e_din = 0; e_busy = 0; e_done = 0;
    e_pass = 0; e_err = 0; e_ferr = 0; ck_din = 1'b1;
    if (kind == 1) begin
      aborted = (m_ab != 0) && (c > m_ab);
      lim     = aborted ? m_ab : c;
      e_err   = errs_at(lim);
      e_ferr  = ferr_at(lim);
      if (aborted) begin
      end else if (c <= m_n) begin
        e_wen = 1; e_busy = 1;
        e_addr = (m_base + c - 1) % NW;
        e_din  = (m_seed + c - 1) % 256;
      end else if (c <= 3*m_n) begin
        e_busy = 1;
        e_addr = (m_base + (c - m_n - 1) / 2) % NW;
        ck_din = 1'b0;
      end else begin
        e_pass = (e_err == 0) ? 1 : 0;
        e_done = (c == 3*m_n + 1) ? 1 : 0;
      end
    end
    chk("mem_wen", int'(mem_wen), e_wen);
    chk("mem_addr", int'(mem_addr), e_addr);
    if (ck_din) chk("mem_din", int'(mem_din), e_din);
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
    chk("pass", int'(pass), e_pass);
    chk("err_count", int'(err_count), e_err);
    if (e_err != 0) chk("first_err_addr", int'(first_err_addr), e_ferr);
  end

  task automatic clear_faults();
    for (int a = 0; a < NW; a++) begin f_en[a] = 1'b0; f_val[a] = '0; end
  endtask

  // ab: abort cycle, sp: extra start pulse cycle, rc: reset cycle (0 = none each).
  task automatic do_run(input int b, input int s, input int cnt, input int ab,
                        input int sp, input int rc, output int done_at);
    int c, endc;
    @(negedge clk); #1;
    m_base = b; m_seed = s; m_n = (cnt > NW) ? NW : cnt; m_ab = ab;
    for (int j = 0; j < NW; j++) begin
      int a;
      a = (b + j) % NW;
      mm[j] = (j < m_n) && f_en[a] && (int'(f_val[a]) != (s + j) % 256);
    end
    kind = 1; t_start = cyc;
    start = 1'b1; base_addr = AB'(b); seed = DW'(s); count = (AB+1)'(cnt);
    endc = (ab != 0) ? ab + 1 : 3*m_n + 2;
    if (rc != 0) endc = rc;
    done_at = 0;
    for (int k = 0; k < endc + 5; k++) begin
      @(negedge clk);
      c = cyc - t_start;
      if (done && done_at == 0) done_at = c;
      #1;
      if (rc != 0 && c == rc) begin
        rst_n = 1'b0; kind = 0; start = 1'b0; abort = 1'b0;
        #1;
        chk("rst_mem_wen", int'(mem_wen), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_count), 0);
        break;
      end
      start = (c == sp) || (ab == 0 && c == 3*m_n + 1);
      abort = (c == ab);
      base_addr = AB'($urandom); seed = DW'($urandom); count = (AB+1)'($urandom);
      if (c >= endc) break;
    end
    if (c < endc) chk("run_bound", c, endc);
  endtask

  task automatic idle_gap(input int n, input bit rnd_abort);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      abort = rnd_abort ? 1'($urandom) : 1'b0;
    end
    @(negedge clk); #1 abort = 1'b0;
  endtask

  initial begin
    int d, nn, ab, sp, cnt;
    for (int a = 0; a < NW; a++) tb_mem[a] = '0;
    clear_faults();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    do_run(12, 10, 8, 0, 0, 0, d);
    chk("basic_done_cycle", d, 25);
    chk("basic_pass", int'(pass), 1);
    chk("basic_err", int'(err_count), 0);
    chk("basic_mem12", int'(tb_mem[12]), 10);
    chk("basic_mem19", int'(tb_mem[19]), 17);
    idle_gap(2, 1'b1);

    mem_reg = 1'b1;
    do_run(30, 254, 4, 0, 0, 0, d);
    chk("wrap_pass", int'(pass), 1);
    chk("wrap_mem30", int'(tb_mem[30]), 254);
    chk("wrap_mem31", int'(tb_mem[31]), 255);
    chk("wrap_mem0", int'(tb_mem[0]), 0);
    chk("wrap_mem1", int'(tb_mem[1]), 1);
    mem_reg = 1'b0;

    f_en[14] = 1'b1; f_en[17] = 1'b1;
    do_run(12, 10, 8, 0, 0, 0, d);
    chk("fault_err", int'(err_count), 2);
    chk("fault_first", int'(first_err_addr), 14);
    chk("fault_pass", int'(pass), 0);
    clear_faults();

    do_run(7, 99, 0, 0, 0, 0, d);
    chk("zero_done_cycle", d, 1);
    chk("zero_pass", int'(pass), 1);

    do_run(3, 85, 40, 0, 0, 0, d);
    chk("sat_done_cycle", d, 97);
    chk("sat_err", int'(err_count), 0);

    do_run(12, 10, 8, 0, 3, 0, d);
    chk("restart_done_cycle", d, 25);
    chk("restart_pass", int'(pass), 1);

    do_run(12, 10, 8, 5, 0, 0, d);
    chk("abort_no_done", d, 0);
    chk("abort_pass", int'(pass), 0);
    do_run(12, 10, 8, 0, 0, 10, d);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int r = 0; r < 30; r++) begin
      for (int a = 0; a < NW; a++) begin
        f_en[a]  = ($urandom % 8) == 0;
        f_val[a] = DW'($urandom);
      end
      mem_reg = 1'($urandom);
      cnt = (($urandom % 6) == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 32));
      nn  = (cnt > NW) ? NW : cnt;
      ab  = (nn > 0 && ($urandom % 4) == 0) ? int'($urandom_range(1, 3*nn)) : 0;
      sp  = (ab == 0 && nn > 0 && ($urandom % 2) == 1) ? int'($urandom_range(1, 3*nn)) : 0;
      do_run(int'($urandom % NW), int'($urandom % 256), cnt, ab, sp, 0, d);
      idle_gap(int'($urandom_range(0, 3)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bist.md
MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of memory data.
REQ-002 SHALL have parameter ADDR_BITS, default 5, width of memory address (2^ADDR_BITS words).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request a fill-and-check run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a run in progress.
REQ-007 SHALL have port base_addr  input  ADDR_BITS  first address of the run.
REQ-008 SHALL have port count  input  ADDR_BITS+1  number of words to test.
REQ-009 SHALL have port seed  input  DATA_WIDTH  pattern value for the first word.
REQ-010 SHALL have port mem_addr  output  ADDR_BITS  address to downstream register memory.
REQ-011 SHALL have port mem_din  output  DATA_WIDTH  write data to memory.
REQ-012 SHALL have port mem_wen  output  1  write enable to memory; memory writes on the clk edge while high.
REQ-013 SHALL have port mem_dout  input  DATA_WIDTH  read data from memory.
REQ-014 SHALL have port busy  output  1  high in WRITE, RD_ADDR, RD_CMP.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port pass  output  1  high when the last completed run had zero mismatches.
REQ-017 SHALL have port err_count  output  ADDR_BITS+1  mismatches in the last run.
REQ-018 SHALL have port first_err_addr  output  ADDR_BITS  address of the first mismatch; meaningful only when err_count != 0.

Function
REQ-019 SHALL implement states IDLE, WRITE, RD_ADDR, RD_CMP, DONE; all outputs driven from registers.
REQ-020 Beat i (0..N-1) SHALL use address (base_addr + i) mod 2^ADDR_BITS and data (seed + i) mod 2^DATA_WIDTH.
REQ-021 Effective N SHALL be count, saturated to 2^ADDR_BITS when count exceeds it.
REQ-022 IDLE: on start=1, latch base_addr/seed/N, clear err_count to 0, first_err_addr to 0, pass to 0; go to WRITE if N>0, else DONE.
REQ-023 WRITE: one beat per cycle, mem_wen=1 with beat address/data; after beat N-1 go to RD_ADDR with beat index reset to 0.
REQ-024 RD_ADDR: present beat address with mem_wen=0; next cycle RD_CMP with address held unchanged.
REQ-025 RD_CMP: compare mem_dout to expected beat data; on mismatch increment err_count and, if first mismatch, capture address into first_err_addr; go to RD_ADDR for the next beat, or DONE after beat N-1.
REQ-026 The two-cycle read beat SHALL tolerate either combinational or one-cycle-registered memory read.
REQ-027 DONE: done=1 for exactly one cycle, pass=(err_count==0) including the final compare, then IDLE.
REQ-028 Latency: with start sampled at edge 0, done SHALL be high in cycle 3N+1; for N=0, in cycle 1.
REQ-029 pass, err_count, first_err_addr SHALL hold their values from DONE until the next accepted start.
REQ-030 start while not IDLE SHALL be ignored; start in DONE SHALL be ignored.
REQ-031 abort=1 in WRITE/RD_ADDR/RD_CMP SHALL return to IDLE next edge, mem_wen=0, no done pulse, pass=0; results not updated further. abort SHALL have priority over all other transitions; abort in IDLE has no effect.
REQ-032 In IDLE and DONE, mem_wen SHALL be 0 and mem_addr/mem_din 0.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, mem_wen=0, mem_addr=0, mem_din=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, including mid-run.
REQ-034 After rst_n deassertion the block SHALL accept start on the first rising edge.

Verification
REQ-035 base_addr=12, seed=10, count=8, ideal memory -> writes 10..17 to addresses 12..19, done in cycle 25, pass=1, err_count=0.
REQ-036 base_addr=30, seed=0xFE, count=4 -> addresses 30,31,0,1 with data FE,FF,00,01, pass=1.
REQ-037 Same as REQ-035 but memory model returns 0x00 at addresses 14 and 17 -> err_count=2, first_err_addr=14, pass=0.
REQ-038 count=0 -> no mem_wen pulse, done in cycle 1, pass=1; count=40 -> 32 words tested, done in cycle 97.
REQ-039 abort in cycle 5 of REQ-035, then rst_n pulse mid-rerun -> no done, mem_wen low next edge/immediately, all outputs at reset values.
REQ-040 start pulsed again while busy -> ignored; run completes with original parameters.
